psi_seq: RTL and testbench



---
 rtl/psi_pkg.sv | 21 ++
 rtl/psi_bitcount_serial.sv | 46 ++++
 rtl/psi_seq.sv | 112 +++++++++++
 tb/tb_psi_seq.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/psi_pkg.sv
// Shared definitions for the PSI controllers: sequencing states and
// width helpers for party and count registers.
package psi_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      COUNT = 2'd2,
      DONE  = 2'd3
   } psi_state_t;

   // Width needed to hold a population count of 0..w.
   function automatic int psi_count_width(input int w);
      return $clog2(w + 1);
   endfunction

   function automatic int psi_party_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/psi_bitcount_serial.sv
// Serial popcount: loads a bitmap, then adds one LSB per enabled cycle
// for W cycles. done marks the final counting cycle.
module psi_bitcount_serial
   import psi_pkg::*;
#(
   parameter int W  = 10,
   parameter int CW = psi_count_width(W)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          load,
   input  logic [W-1:0]  load_data,
   input  logic          en,
   output logic [CW-1:0] count,
   output logic          done
);

   logic [W-1:0]  shreg;
   logic [CW-1:0] bit_cnt;

   // Decoded from registers and the FSM state only, so the FSM can leave
   // COUNT on the same edge that adds the last bit.
   assign done = en && (bit_cnt == CW'(W - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg   <= '0;
         bit_cnt <= '0;
         count   <= '0;
      end else begin
         if (clr) begin
            count <= '0;
         end
         if (load) begin
            shreg   <= load_data;
            bit_cnt <= '0;
         end else if (en) begin
            count   <= count + CW'(shreg[0]);
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/psi_seq.sv
// Sequential PSI engine: ANDs N party bitmaps into one accumulator, then
// counts the intersection serially and offers bitmap plus count.
//
// state | meaning
// IDLE  | waiting for start; accumulator holds the last result
// ACCUM | accepting party bitmaps, exactly N transfers
// COUNT | serial popcount of the accumulated bitmap, W cycles
// DONE  | result presented on the output port until accepted
module psi_seq
   import psi_pkg::*;
#(
   parameter  int W  = 10,
   parameter  int N  = 4,
   localparam int CW = psi_count_width(W),
   localparam int PW = psi_party_width(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_data,
   output logic [CW-1:0] out_count,
   output logic          busy
);

   psi_state_t    state_q, state_d;
   logic [W-1:0]  acc_q;
   logic [PW-1:0] party_cnt_q;
   logic          acc_init, xfer, last_xfer;
   logic          count_clr, count_load, count_en, count_done;

   assign xfer      = in_ready && in_valid;
   assign last_xfer = xfer && (party_cnt_q == PW'(N - 1));
   assign out_data  = acc_q;

   always_comb begin
      state_d    = state_q;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = (state_q != IDLE);
      acc_init   = 1'b0;
      count_clr  = 1'b0;
      count_load = 1'b0;
      count_en   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               acc_init  = 1'b1;
               count_clr = 1'b1;
               state_d   = ACCUM;
            end
         end
         ACCUM: begin
            in_ready = 1'b1;
            if (last_xfer) begin
               count_load = 1'b1;
               state_d    = COUNT;
            end
         end
         COUNT: begin
            count_en = 1'b1;
            if (count_done) begin
               state_d = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         party_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         if (acc_init) begin
            acc_q       <= '1;
            party_cnt_q <= '0;
         end else if (xfer) begin
            acc_q       <= acc_q & in_data;
            party_cnt_q <= party_cnt_q + PW'(1);
         end
      end
   end

   // The shifter is loaded with the post-AND value on the final transfer.
   psi_bitcount_serial #(
      .W  (W),
      .CW (CW)
   ) u_bitcount (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (count_clr),
      .load      (count_load),
      .load_data (acc_q & in_data),
      .en        (count_en),
      .count     (out_count),
      .done      (count_done)
   );

endmodule

// File: tb/tb_psi_seq.sv
// Scoreboard bench for psi_seq: expected results come from a plain
// AND/popcount model and are checked whenever out_valid is presented.
module tb_psi_seq;

   localparam int W  = 10;
   localparam int N  = 4;
   localparam int CW = $clog2(W + 1);

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          start = 1'b0;
   logic          in_valid = 1'b0;
   logic [W-1:0]  in_data = '0;
   logic          out_ready = 1'b0;
   logic          in_ready, out_valid, busy;
   logic [W-1:0]  out_data;
   logic [CW-1:0] out_count;

   typedef struct packed {
      logic [W-1:0]  data;
      logic [CW-1:0] cnt;
   } res_t;

   res_t       exp_q[$];
   logic [W-1:0] bm[N];
   int         compared = 0;
   int         mismatched = 0;
   int         cyc = 0;
   int         xfer_cnt = 0;

   psi_seq #(.W(W), .N(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_count (out_count),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every cycle out_valid is high the presented result must equal
   // the oldest expected one; it is retired on the handshake.
   always @(negedge clk) begin
      if (rst_n) begin
         if (in_valid && in_ready) xfer_cnt <= xfer_cnt + 1;
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               compared++;
               mismatched++;
               $display("FAIL unexpected_result: out_valid with data 0x%0h count %0d, nothing expected",
                        out_data, out_count);
            end else begin
               chk("out_data", 32'(out_data), 32'(exp_q[0].data));
               chk("out_count", 32'(out_count), 32'(exp_q[0].cnt));
               if (out_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full run using bm[]. Entered and left at posedge+1; the start
   // cycle is the cycle right after the previous handshake.
   task automatic run_seq(input bit gap, input bit noise, input int bp, input bit check_lat);
      res_t e;
      int   c0, x0, p, guard, lat;
      bit   ph;
      e.data = '1;
      for (int i = 0; i < N; i++) e.data &= bm[i];
      e.cnt = CW'($countones(e.data));
      exp_q.push_back(e);
      c0    = cyc;
      x0    = xfer_cnt;
      start = 1'b1;
      @(negedge clk);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_in_ready", 32'(in_ready), 0);
      chk("idle_out_valid", 32'(out_valid), 0);
      tick();
      start = noise;
      p = 0; ph = 1'b1; guard = 0;
      while (p < N && guard < 100) begin
         in_valid = gap ? ph : 1'b1;
         ph       = ~ph;
         in_data  = in_valid ? bm[p] : W'($urandom);
         @(negedge clk);
         if (in_valid && in_ready) p++;
         tick();
         guard++;
      end
      if (p < N) begin
         compared++; mismatched++;
         $display("FAIL input_timeout: accepted %0d of %0d bitmaps", p, N);
      end
      in_valid = noise;
      in_data  = W'($urandom);
      lat = -1;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (out_valid) begin
            lat = cyc - c0;
            break;
         end
         tick();
      end
      tick();
      if (lat < 0) begin
         compared++; mismatched++;
         $display("FAIL result_timeout: out_valid never rose");
      end else if (check_lat) begin
         chk("latency", 32'(lat), 32'(1 + N + W));
      end
      for (int k = 0; k < bp; k++) begin
         start = noise ? 1'($urandom) : 1'b0;
         tick();
      end
      out_ready = 1'b1;
      start     = noise;
      tick();
      out_ready = 1'b0;
      start     = 1'b0;
      in_valid  = 1'b0;
      chk("transfers", 32'(xfer_cnt - x0), 32'(N));
   endtask

   initial begin
      #2 rst_n = 1'b0;
      #1;
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_out_data", 32'(out_data), 0);
      chk("rst_out_count", 32'(out_count), 0);
      tick(); tick();
      rst_n = 1'b1;
      tick();

      bm = '{10'h3FF, 10'h2AA, 10'h0FA, 10'h3AB};
      run_seq(1'b0, 1'b0, 0, 1'b1);
      bm = '{10'h00F, 10'h3F0, 10'h3FF, 10'h3FF};
      run_seq(1'b0, 1'b0, 0, 1'b1);
      bm = '{10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF};
      run_seq(1'b1, 1'b0, 0, 1'b0);
      for (int i = 0; i < N; i++) bm[i] = W'($urandom) | W'($urandom);
      run_seq(1'b0, 1'b1, 5, 1'b1);

      // Abort a run after two accepted bitmaps.
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1;
         in_data  = W'($urandom);
         tick();
      end
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_in_ready", 32'(in_ready), 0);
      chk("midrst_out_valid", 32'(out_valid), 0);
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_out_data", 32'(out_data), 0);
      chk("midrst_out_count", 32'(out_count), 0);
      in_valid = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      tick();

      bm = '{10'h155, 10'h155, 10'h155, 10'h155};
      run_seq(1'b0, 1'b0, 0, 1'b1);

      for (int r = 0; r < 8; r++) begin
         bit g;
         g = 1'($urandom);
         for (int i = 0; i < N; i++) bm[i] = W'($urandom) | W'($urandom);
         run_seq(g, 1'($urandom), $urandom_range(0, 3), !g);
      end

      @(negedge clk);
      chk("final_idle", 32'(busy), 0);
      chk("queue_drained", 32'(exp_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
      $fatal(1, "watchdog");
   end

endmodule
